// File: rtl/bus_interconnect.sv
// Single-outstanding N-master / N-slave interconnect: round-robin grant, base/mask
// address decode, multi-cycle slave waits, watchdog timeout and registered decode errors.
module bus_interconnect #(
  parameter int XLEN      = 32,
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3,
  parameter logic [N_SLAVES*XLEN-1:0] SLV_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000},
  parameter logic [N_SLAVES*XLEN-1:0] SLV_MASK = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_0000},
  parameter int TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTERS-1:0]    m_valid,
  input  logic [N_MASTERS*XLEN-1:0] m_addr,
  input  logic [N_MASTERS*64-1:0] m_wdata,
  input  logic [N_MASTERS-1:0]    m_we,
  input  logic [N_MASTERS*3-1:0]  m_size,
  output logic [N_MASTERS-1:0]    m_ready,
  output logic [N_MASTERS-1:0]    m_error,
  output logic [63:0]             m_rdata,
  output logic [N_SLAVES-1:0]     s_valid,
  output logic [XLEN-1:0]         s_addr,
  output logic [63:0]             s_wdata,
  output logic                    s_we,
  output logic [2:0]              s_size,
  input  logic [N_SLAVES-1:0]     s_ready,
  input  logic [N_SLAVES*64-1:0]  s_rdata,
  output logic [1:0]              state_dbg
);

  // Handshake: a master holds m_valid (and its fields) until it sees m_ready; m_ready
  // is a one-cycle pulse, qualified by m_error. A slave sees s_valid held until s_ready.

  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]      state;
  logic [MW-1:0]   last_grant;
  logic [MW-1:0]   grant;
  logic [SW-1:0]   sel;
  logic [TW-1:0]   tcnt;
  logic [XLEN-1:0] addr_q;
  logic [63:0]     wdata_q;
  logic            we_q;
  logic [2:0]      size_q;

  logic            arb_found;
  logic [MW-1:0]   arb_idx;
  logic [XLEN-1:0] req_addr;
  logic            dec_hit;
  logic [SW-1:0]   dec_sel;

  // Search starts just after last_grant so the previous owner is considered last.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      if (!arb_found && m_valid[(int'(last_grant) + i) % N_MASTERS]) begin
        arb_found = 1'b1;
        arb_idx   = MW'((int'(last_grant) + i) % N_MASTERS);
      end
    end
  end

  assign req_addr = m_addr[arb_idx*XLEN +: XLEN];

  // Scan from the top so the lowest-index matching window overrides on overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((req_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= MW'(N_MASTERS - 1);
      grant      <= '0;
      sel        <= '0;
      tcnt       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant   <= arb_idx;
            addr_q  <= req_addr;
            wdata_q <= m_wdata[arb_idx*64 +: 64];
            we_q    <= m_we[arb_idx];
            size_q  <= m_size[arb_idx*3 +: 3];
            tcnt    <= '0;
            if (dec_hit) begin
              sel   <= dec_sel;
              state <= BUSY;
            end else begin
              state <= ERR;
            end
          end
        end
        BUSY: begin
          if (s_ready[sel]) begin
            state      <= IDLE;
            last_grant <= grant;
          end else begin
            if (tcnt != '1) tcnt <= tcnt + TW'(1);
            if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) state <= ERR;
          end
        end
        ERR: begin
          state      <= IDLE;
          last_grant <= grant;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is combinational on s_ready so a zero-wait slave finishes in one BUSY cycle.
  always_comb begin
    s_valid = '0;
    m_ready = '0;
    m_error = '0;
    m_rdata = '0;
    if (state == BUSY) begin
      s_valid[sel] = 1'b1;
      if (s_ready[sel]) begin
        m_ready[grant] = 1'b1;
        m_rdata        = s_rdata[sel*64 +: 64];
      end
    end else if (state == ERR) begin
      m_ready[grant] = 1'b1;
      m_error[grant] = 1'b1;
    end
  end

  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_we      = we_q;
  assign s_size    = size_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: zero-wait read, round-robin alternation, decode
// error, watchdog timeout, multi-cycle write with stable latches, reset mid-transaction.
module tb_bus_interconnect;

  logic          clk;
  logic          reset;
  logic [1:0]    m_valid;
  logic [63:0]   m_addr;
  logic [127:0]  m_wdata;
  logic [1:0]    m_we;
  logic [5:0]    m_size;
  logic [1:0]    m_ready;
  logic [1:0]    m_error;
  logic [63:0]   m_rdata;
  logic [2:0]    s_valid;
  logic [31:0]   s_addr;
  logic [63:0]   s_wdata;
  logic          s_we;
  logic [2:0]    s_size;
  logic [2:0]    s_ready;
  logic [191:0]  s_rdata;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_grant;

  bus_interconnect dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_size(m_size),
    .m_ready(m_ready), .m_error(m_error), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_size(s_size),
    .s_ready(s_ready), .s_rdata(s_rdata), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic v, input logic [31:0] a,
                       input logic [63:0] d, input logic we, input logic [2:0] sz);
    m_valid[i]        = v;
    m_addr[i*32 +: 32] = a;
    m_wdata[i*64 +: 64] = d;
    m_we[i]           = we;
    m_size[i*3 +: 3]  = sz;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    m_valid = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = '0;
    m_size  = '0;
    s_ready = '0;
    s_rdata = {64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0000_0055, 64'h0000_0000_0000_CAFE};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("rst_state", state_dbg, 2'd0);
    check("rst_s_valid", s_valid, 3'b000);
    check("rst_m_ready", m_ready, 2'b00);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wdata", s_wdata, 64'h0);
    check("rst_m_rdata", m_rdata, 64'h0);

    // Test 1: zero-wait DMEM read by M0
    cyc();
    set_m(0, 1'b1, 32'h8000_0010, 64'h0, 1'b0, 3'd2);
    #2;
    check("t1_accept_m_ready", m_ready, 2'b00);
    cyc();
    s_ready = 3'b100;
    #2;
    check("t1_s_valid", s_valid, 3'b100);
    check("t1_s_addr", s_addr, 32'h8000_0010);
    check("t1_m_ready", m_ready, 2'b01);
    check("t1_m_error", m_error, 2'b00);
    check("t1_m_rdata", m_rdata, 64'hDEAD_BEEF);
    cyc();
    set_m(0, 1'b0, 32'h0, 64'h0, 1'b0, 3'd0);
    s_ready = 3'b000;
    #2;
    check("t1_idle_state", state_dbg, 2'd0);
    check("t1_idle_s_valid", s_valid, 3'b000);

    // Test 2: both masters continuously request DMEM; reset first so M0 leads
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_m(0, 1'b1, 32'h8000_0020, 64'h0, 1'b0, 3'd3);
    set_m(1, 1'b1, 32'h8000_0040, 64'h0, 1'b0, 3'd3);
    s_ready = 3'b100;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    for (int c = 0; c < 8; c++) begin
      #2;
      if (c % 2 == 0) begin
        check("t2_idle_s_valid", s_valid, 3'b000);
        check("t2_idle_m_ready", m_ready, 2'b00);
      end else begin
        exp_grant = exp_q.pop_front();
        check("t2_grant", m_ready, exp_grant);
        check("t2_s_addr", s_addr, (exp_grant == 2'b01) ? 32'h8000_0020 : 32'h8000_0040);
      end
      cyc();
    end

    // Test 3: M1 decode miss
    set_m(0, 1'b0, 32'h0, 64'h0, 1'b0, 3'd0);
    set_m(1, 1'b1, 32'h4000_0000, 64'h0, 1'b0, 3'd2);
    s_ready = 3'b111;
    #2;
    check("t3_accept_m_ready", m_ready, 2'b00);
    cyc();
    #2;
    check("t3_state_err", state_dbg, 2'd2);
    check("t3_s_valid", s_valid, 3'b000);
    check("t3_m_ready", m_ready, 2'b10);
    check("t3_m_error", m_error, 2'b10);
    check("t3_m_rdata", m_rdata, 64'h0);
    cyc();

    // Test 4: M0 writes UART which never responds
    set_m(1, 1'b0, 32'h0, 64'h0, 1'b0, 3'd0);
    set_m(0, 1'b1, 32'h1000_0005, 64'h0000_0000_0000_00A5, 1'b1, 3'd0);
    s_ready = 3'b000;
    #2;
    check("t4_accept_m_ready", m_ready, 2'b00);
    cyc();
    s_ready = 3'b101;
    for (int c = 0; c < 16; c++) begin
      #2;
      check("t4_busy_s_valid", s_valid, 3'b010);
      check("t4_busy_m_ready", m_ready, 2'b00);
      cyc();
    end
    #2;
    check("t4_timeout_m_ready", m_ready, 2'b01);
    check("t4_timeout_m_error", m_error, 2'b01);
    check("t4_timeout_s_valid", s_valid, 3'b000);
    cyc();

    // Test 5: CLINT write with a 3-cycle slave wait
    set_m(0, 1'b1, 32'h0200_4000, 64'h0000_0000_0000_1234, 1'b1, 3'd3);
    s_ready = 3'b000;
    #2;
    check("t5_idle_state", state_dbg, 2'd0);
    cyc();
    set_m(0, 1'b1, 32'hFFFF_FFFF, 64'h0, 1'b0, 3'd0);
    for (int c = 0; c < 4; c++) begin
      s_ready = (c == 3) ? 3'b001 : 3'b000;
      #2;
      check("t5_s_valid", s_valid, 3'b001);
      check("t5_s_addr", s_addr, 32'h0200_4000);
      check("t5_s_wdata", s_wdata, 64'h1234);
      check("t5_s_we", s_we, 1'b1);
      check("t5_s_size", s_size, 3'd3);
      check("t5_m_ready", m_ready, (c == 3) ? 2'b01 : 2'b00);
      cyc();
    end
    check("t5_m_rdata_after", m_rdata, 64'h0);

    // Test 6: reset during a BUSY wait, then simultaneous requests
    set_m(0, 1'b0, 32'h0, 64'h0, 1'b0, 3'd0);
    set_m(1, 1'b1, 32'h8000_0080, 64'h77, 1'b1, 3'd2);
    s_ready = 3'b000;
    cyc();
    #2;
    check("t6_busy_s_valid", s_valid, 3'b100);
    cyc();
    reset = 1'b1;
    #2;
    check("t6_busy2_s_valid", s_valid, 3'b100);
    cyc();
    reset = 1'b0;
    set_m(1, 1'b0, 32'h0, 64'h0, 1'b0, 3'd0);
    s_ready = 3'b111;
    #2;
    check("t6_post_state", state_dbg, 2'd0);
    check("t6_post_s_valid", s_valid, 3'b000);
    check("t6_post_m_ready", m_ready, 2'b00);
    check("t6_post_s_addr", s_addr, 32'h0);
    check("t6_post_s_wdata", s_wdata, 64'h0);
    check("t6_post_s_we", s_we, 1'b0);
    check("t6_post_s_size", s_size, 3'd0);
    cyc();
    set_m(0, 1'b1, 32'h8000_0000, 64'h0, 1'b0, 3'd2);
    set_m(1, 1'b1, 32'h8000_0080, 64'h0, 1'b0, 3'd2);
    s_ready = 3'b100;
    #2;
    check("t6_accept_m_ready", m_ready, 2'b00);
    cyc();
    #2;
    check("t6_first_grant", m_ready, 2'b01);
    check("t6_first_addr", s_addr, 32'h8000_0000);
    check("t6_first_rdata", m_rdata, 64'hDEAD_BEEF);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
